// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: PS/2 device-to-host frame receiver with glitch filter, timeout and a one-byte output holding register.
module ps2_frame_rx #(
  parameter int FILT_LEN    = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun
);
  localparam int FW = $clog2(FILT_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic          r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic          r_filt, r_filt_d;
  logic [FW-1:0] r_fcnt;
  logic [TW-1:0] r_tcnt;
  state_t        r_state;
  logic [2:0]    r_bitcnt;
  logic [7:0]    r_shift;
  logic          r_par;
  logic          w_fall, w_bit, w_par_ok, w_tout;

  assign w_fall   = r_filt_d & ~r_filt;
  assign w_bit    = r_dat_s2;
  assign w_par_ok = ^{r_par, r_shift};
  assign w_tout   = (r_state != IDLE) && (r_tcnt == TW'(TIMEOUT_CYC));

  // Everything idles high so releasing reset never looks like a falling edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
      r_filt   <= 1'b1;
      r_filt_d <= 1'b1;
      r_fcnt   <= '0;
    end else begin
      r_clk_s1 <= ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= ps2_data;
      r_dat_s2 <= r_dat_s1;
      r_filt_d <= r_filt;
      if (r_clk_s2 == r_filt) begin
        r_fcnt <= '0;
      end else if (r_fcnt == FW'(FILT_LEN - 1)) begin
        r_filt <= r_clk_s2;
        r_fcnt <= '0;
      end else begin
        r_fcnt <= r_fcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_bitcnt   <= '0;
      r_shift    <= '0;
      r_par      <= 1'b0;
      r_tcnt     <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      r_tcnt     <= (w_fall || r_state == IDLE) ? '0 : r_tcnt + 1'b1;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      if (w_fall) begin
        case (r_state)
          IDLE: begin
            if (w_bit) frame_err <= 1'b1;
            else begin
              r_state  <= DATA;
              r_bitcnt <= '0;
            end
          end
          DATA: begin
            r_shift  <= {w_bit, r_shift[7:1]};
            r_bitcnt <= r_bitcnt + 1'b1;
            if (r_bitcnt == 3'd7) r_state <= PARITY;
          end
          PARITY: begin
            r_par   <= w_bit;
            r_state <= STOP;
          end
          default: begin
            r_state <= IDLE;
            // A held byte accepted this very cycle frees the register for the new one.
            if (!w_bit) frame_err <= 1'b1;
            else if (!w_par_ok) parity_err <= 1'b1;
            else if (!rx_valid || rx_ready) begin
              rx_data  <= r_shift;
              rx_valid <= 1'b1;
            end else overrun <= 1'b1;
          end
        endcase
      end else if (w_tout) begin
        r_state   <= IDLE;
        r_shift   <= '0;
        r_bitcnt  <= '0;
        frame_err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ps2_frame_rx.sv
// tb_ps2_frame_rx: directed table, hand sequences and randomized frames against a frame-level model.
module tb_ps2_frame_rx;
  localparam int H = 12;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, parity_err, frame_err, overrun;

  int n_chk = 0, n_pass = 0;
  int c_perr = 0, c_ferr = 0, c_ovr = 0, c_rise = 0;
  int b_perr, b_ferr, b_ovr, b_rise;
  logic prev_v = 1'b0;

  typedef struct {
    logic [7:0] d;
    bit p, s, rdy, cons;
    logic [7:0] ed;
    bit ev;
    int ep, ef, eo, er;
  } vec_t;
  vec_t tv[10];

  always #5 clk = ~clk;

  ps2_frame_rx dut (
    .clk(clk), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .parity_err(parity_err), .frame_err(frame_err), .overrun(overrun)
  );

  // Pulses are counted as high cycles, so a stretched pulse shows up as an extra count.
  always @(negedge clk) begin
    c_perr <= c_perr + int'(parity_err);
    c_ferr <= c_ferr + int'(frame_err);
    c_ovr  <= c_ovr + int'(overrun);
    c_rise <= c_rise + int'(rx_valid && !prev_v);
    prev_v <= rx_valid;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic snap();
    b_perr = c_perr;
    b_ferr = c_ferr;
    b_ovr  = c_ovr;
    b_rise = c_rise;
  endtask

  task automatic check_all(input string nm, input logic [7:0] ed, input bit ev,
                           input int ep, input int ef, input int eo, input int er);
    chk({nm, " rx_data"}, int'(rx_data), int'(ed));
    chk({nm, " rx_valid"}, int'(rx_valid), int'(ev));
    chk({nm, " parity_err"}, c_perr - b_perr, ep);
    chk({nm, " frame_err"}, c_ferr - b_ferr, ef);
    chk({nm, " overrun"}, c_ovr - b_ovr, eo);
    chk({nm, " valid_rise"}, c_rise - b_rise, er);
  endtask

  task automatic send_bit(input bit b);
    ps2_data = b;
    tick(H);
    ps2_clk = 1'b0;
    tick(H);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit p, input bit s);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(p);
    send_bit(s);
    ps2_data = 1'b1;
    tick(30);
  endtask

  task automatic consume();
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    tick(2);
  endtask

  initial begin
    logic [7:0] md, rd;
    bit mv, pok, rs, rc, good;

    tv[0] = '{8'h1C, 0, 1, 1, 0, 8'h1C, 0, 0, 0, 0, 1};
    tv[1] = '{8'h1C, 1, 1, 1, 0, 8'h1C, 0, 1, 0, 0, 0};
    tv[2] = '{8'h1C, 0, 0, 1, 0, 8'h1C, 0, 0, 1, 0, 0};
    tv[3] = '{8'h1C, 1, 0, 1, 0, 8'h1C, 0, 0, 1, 0, 0};
    tv[4] = '{8'h1C, 0, 1, 0, 0, 8'h1C, 1, 0, 0, 0, 1};
    tv[5] = '{8'h12, 1, 1, 0, 0, 8'h1C, 1, 0, 0, 1, 0};
    tv[6] = '{8'hF0, 1, 1, 0, 1, 8'h1C, 0, 0, 0, 1, 0};
    tv[7] = '{8'hA5, 1, 1, 0, 0, 8'hA5, 1, 0, 0, 0, 1};
    tv[8] = '{8'h00, 1, 1, 1, 0, 8'h00, 0, 0, 0, 0, 1};
    tv[9] = '{8'hFF, 1, 1, 1, 0, 8'hFF, 0, 0, 0, 0, 1};

    snap();
    tick(5);
    check_all("reset", 8'h00, 0, 0, 0, 0, 0);
    reset_n = 1'b1;
    tick(5);

    for (int i = 0; i < 10; i++) begin
      rx_ready = tv[i].rdy;
      tick(1);
      snap();
      send_frame(tv[i].d, tv[i].p, tv[i].s);
      if (tv[i].cons) consume();
      check_all($sformatf("vec%0d", i), tv[i].ed, tv[i].ev, tv[i].ep, tv[i].ef, tv[i].eo, tv[i].er);
    end

    rx_ready = 1'b1;
    tick(3);
    snap();
    send_bit(1'b1);
    tick(30);
    check_all("bad_start", 8'hFF, 0, 0, 1, 0, 0);

    snap();
    ps2_clk = 1'b0;
    tick(3);
    ps2_clk = 1'b1;
    tick(20);
    chk("glitch frame_err", c_ferr - b_ferr, 0);
    send_frame(8'hF0, 1, 1);
    check_all("glitch", 8'hF0, 0, 0, 0, 0, 1);

    snap();
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(i[0]);
    tick(60000);
    check_all("timeout", 8'hF0, 0, 0, 1, 0, 0);
    snap();
    send_frame(8'h12, 1, 1);
    check_all("after_timeout", 8'h12, 0, 0, 0, 0, 1);

    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    reset_n = 1'b0;
    tick(3);
    reset_n = 1'b1;
    tick(5);
    chk("midreset rx_data", int'(rx_data), 0);
    snap();
    send_frame(8'h5A, 1, 1);
    check_all("after_reset", 8'h5A, 0, 0, 0, 0, 1);

    rx_ready = 1'b0;
    tick(2);
    mv = 1'b0;
    md = 8'h5A;
    for (int i = 0; i < 20; i++) begin
      rd   = 8'($urandom);
      pok  = ($urandom % 5) != 0;
      rs   = ($urandom % 10) != 0;
      rc   = ($urandom % 2) != 0;
      good = rs && pok;
      snap();
      send_frame(rd, pok ? ~^rd : ^rd, rs);
      if (rc) consume();
      check_all($sformatf("rand%0d", i), good && !mv ? rd : md, (good || mv) && !rc,
                int'(rs && !pok), int'(!rs), int'(good && mv), int'(good && !mv));
      if (good && !mv) md = rd;
      mv = (good || mv) && !rc;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ps2_frame_rx.md
PS2_FRAME_RX -- requirements
Module: ps2_frame_rx

Interface
- REQ-001: Parameter FILT_LEN, default 8: consecutive identical clk samples needed to accept a new filtered ps2_clk level.
- REQ-002: Parameter TIMEOUT_CYC, default 50000: idle clk cycles mid-frame before the frame is aborted (1 ms at 50 MHz).
- REQ-003: clk  input  1  system clock, 50 MHz; sole clock.
- REQ-004: reset_n  input  1  asynchronous, active-low reset.
- REQ-005: ps2_clk  input  1  raw PS/2 clock pin, asynchronous to clk.
- REQ-006: ps2_data  input  1  raw PS/2 data pin, asynchronous to clk.
- REQ-007: rx_data  output  8  last received scan-code byte.
- REQ-008: rx_valid  output  1  rx_data holds an unconsumed byte.
- REQ-009: rx_ready  input  1  consumer accepts rx_data when rx_valid and rx_ready are both high on a rising clk edge.
- REQ-010: parity_err  output  1  one-cycle pulse when a frame fails odd parity.
- REQ-011: frame_err  output  1  one-cycle pulse on bad start bit, bad stop bit, or timeout.
- REQ-012: overrun  output  1  one-cycle pulse when a good frame completes while rx_valid is high.

Function
- REQ-013: ps2_clk and ps2_data shall each pass through a 2-flop synchronizer before use.
- REQ-014: Filtered ps2_clk shall change level only after FILT_LEN consecutive synchronized samples at the new level; shorter glitches are ignored.
- REQ-015: A falling edge of filtered ps2_clk shall sample the synchronized ps2_data as one frame bit.
- REQ-016: FSM states: IDLE, DATA, PARITY, STOP.
- REQ-017: IDLE: a sampled 0 shall go to DATA with the bit counter at 0; a sampled 1 shall pulse frame_err and stay in IDLE.
- REQ-018: DATA: 8 bits are shifted in LSB first; after the 8th bit, go to PARITY.
- REQ-019: PARITY: capture the parity bit and go to STOP.
- REQ-020: STOP: a sampled 1 with odd parity (9 bits, odd count of ones) completes a good frame.
- REQ-021: STOP: a sampled 0 shall pulse frame_err.
- REQ-022: STOP: bad parity shall pulse parity_err; if both errors occur, only frame_err pulses.
- REQ-023: Every STOP sample shall return the FSM to IDLE.
- REQ-024: Good frame with rx_valid low: rx_data loads the byte and rx_valid rises on the clk edge after the stop-bit falling edge is detected (1-cycle latency).
- REQ-025: Good frame with rx_valid high: rx_data and rx_valid are unchanged, overrun pulses, and the byte is dropped.
- REQ-026: Good frame completing in the same cycle that the held byte is accepted: the new byte loads and rx_valid stays high; no overrun.
- REQ-027: rx_valid shall clear on acceptance unless REQ-026 applies.
- REQ-028: The timeout counter shall clear on every filtered falling edge and count while the FSM is not IDLE.
- REQ-029: When the counter reaches TIMEOUT_CYC, return to IDLE and pulse frame_err; partial data is discarded.
- REQ-030: The error pulses and overrun shall each last exactly one cycle per event.

Reset
- REQ-031: reset_n low shall asynchronously force FSM=IDLE and clear all counters and the shift register.
- REQ-032: Reset values: rx_data=0x00, rx_valid=0, parity_err=0, frame_err=0, overrun=0.
- REQ-033: Synchronizers and filter shall reset to 1 (bus idle), so release of reset causes no spurious edge.
- REQ-034: Reset asserted mid-frame discards the partial frame; the first complete frame after release is received normally.

Verification
- REQ-035: Frame 0x1C, parity 0, stop 1, rx_ready=1 -> rx_data=0x1C, rx_valid high for one cycle, no error pulses.
- REQ-036: Frame 0x1C with parity 1 -> one parity_err pulse, rx_valid stays 0.
- REQ-037: 3-cycle low glitch on ps2_clk during IDLE, then frame 0xF0 with parity 1 -> glitch ignored, rx_data=0xF0.
- REQ-038: Start bit plus 5 data bits, then 60000 idle cycles -> one frame_err pulse and FSM IDLE; following frame 0x12 (parity 1) received as 0x12.
- REQ-039: rx_ready=0, frames 0x1C then 0x12 -> rx_data stays 0x1C with one overrun pulse; after rx_ready=1 for one cycle, rx_valid=0.
- REQ-040: reset_n pulsed low after 4 bits of a frame, then frame 0x5A (parity 1) -> rx_data=0x5A, no error pulses.
